// File: rtl/spram_pkg.sv
// Shared types, legal latency range and the byte parity helper for spram_v2.
package spram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } spram_state_e;

  localparam int RD_LATENCY_MIN = 1;
  localparam int RD_LATENCY_MAX = 2;

  // Even parity: the stored bit makes the total count of ones in byte+bit even.
  function automatic logic byte_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/spram_rd_pipe.sv
// Read response delay line carrying {valid, err, data}; data holds between pulses.
module spram_rd_pipe #(
  parameter int D_WIDTH = 32,
  parameter int LATENCY = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic               in_err,
  input  logic [D_WIDTH-1:0] in_data,
  output logic               out_valid,
  output logic               out_err,
  output logic [D_WIDTH-1:0] out_data
);

  logic [LATENCY-1:0] valid_q;
  logic [LATENCY-1:0] err_q;
  logic [D_WIDTH-1:0] data_q [LATENCY];

  // Every stage keeps its data when no response passes, so the last stage
  // presents the most recent response between pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      err_q   <= '0;
      for (int i = 0; i < LATENCY; i++) data_q[i] <= '0;
    end else begin
      valid_q[0] <= in_valid;
      err_q[0]   <= in_valid && in_err;
      if (in_valid) data_q[0] <= in_data;
      for (int i = 1; i < LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        err_q[i]   <= valid_q[i-1] && err_q[i-1];
        if (valid_q[i-1]) data_q[i] <= data_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[LATENCY-1];
  assign out_err   = err_q[LATENCY-1];
  assign out_data  = data_q[LATENCY-1];

endmodule

// File: rtl/spram_v2.sv
// Single-port RAM with valid/ready requests, byte enables, post-reset clear sequencer.
// Define SPRAM_PARITY_EN to store and check one even-parity bit per byte.
module spram_v2
  import spram_pkg::*;
#(
  parameter int D_WIDTH    = 32,
  parameter int A_WIDTH    = 4,
  parameter int MEM_DEPTH  = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 wr_en,
  input  logic [A_WIDTH-1:0]   address,
  input  logic [D_WIDTH-1:0]   data_in,
  input  logic [D_WIDTH/8-1:0] byte_en,
  output logic [D_WIDTH-1:0]   data_out,
  output logic                 valid_out,
  output logic                 err
);

  localparam int NB = D_WIDTH / 8;
  localparam logic [A_WIDTH-1:0] LAST = A_WIDTH'(MEM_DEPTH - 1);

  if (D_WIDTH < 8 || (D_WIDTH % 8) != 0) begin : g_bad_width
    $fatal(1, "spram_v2: D_WIDTH must be a non-zero multiple of 8");
  end
  if (MEM_DEPTH < 1 || MEM_DEPTH > (2 ** A_WIDTH)) begin : g_bad_depth
    $fatal(1, "spram_v2: MEM_DEPTH must be in 1..2**A_WIDTH");
  end
  if (RD_LATENCY < RD_LATENCY_MIN || RD_LATENCY > RD_LATENCY_MAX) begin : g_bad_latency
    $fatal(1, "spram_v2: RD_LATENCY must be 1 or 2");
  end

  spram_state_e       state, state_next;
  logic [A_WIDTH-1:0] cnt, cnt_next;
  logic               accept;
  logic               in_range;
  logic               req_rd_valid;
  logic [A_WIDTH-1:0] req_addr;
  logic [D_WIDTH-1:0] rd_data;
  logic               rd_err;
  logic [D_WIDTH-1:0] mem [MEM_DEPTH];
`ifdef SPRAM_PARITY_EN
  logic [NB-1:0]      par_mem [MEM_DEPTH];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    req_ready  = 1'b0;
    case (state)
      CLEAR: begin
        cnt_next = cnt + 1'b1;
        if (cnt == LAST) state_next = READY;
      end
      READY:   req_ready = 1'b1;
      default: state_next = CLEAR;
    endcase
  end

  // A reset edge never accepts, even if the FSM was READY before it.
  assign accept   = req_valid && req_ready && rst_n;
  assign in_range = 32'(address) < MEM_DEPTH;

  always_ff @(posedge clk) begin
    if (rst_n && state == CLEAR) begin
      mem[cnt] <= '0;
`ifdef SPRAM_PARITY_EN
      par_mem[cnt] <= '0;
`endif
    end else if (accept && wr_en && in_range) begin
      for (int b = 0; b < NB; b++) begin
        if (byte_en[b]) begin
          mem[address][b*8 +: 8] <= data_in[b*8 +: 8];
`ifdef SPRAM_PARITY_EN
          par_mem[address][b] <= byte_parity(data_in[b*8 +: 8]);
`endif
        end
      end
    end
  end

  // Accepted reads are registered first; the array is read on the next cycle
  // so a write in the acceptance cycle of a later read is always visible.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_rd_valid <= 1'b0;
      req_addr     <= '0;
    end else begin
      req_rd_valid <= accept && !wr_en;
      if (accept && !wr_en) req_addr <= address;
    end
  end

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    if (32'(req_addr) < MEM_DEPTH) begin
      rd_data = mem[req_addr];
`ifdef SPRAM_PARITY_EN
      for (int b = 0; b < NB; b++) begin
        if (par_mem[req_addr][b] != byte_parity(rd_data[b*8 +: 8])) rd_err = 1'b1;
      end
`endif
    end else begin
      rd_err = 1'b1;
    end
  end

  spram_rd_pipe #(
    .D_WIDTH (D_WIDTH),
    .LATENCY (RD_LATENCY)
  ) u_rd_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (req_rd_valid),
    .in_err    (rd_err),
    .in_data   (rd_data),
    .out_valid (valid_out),
    .out_err   (err),
    .out_data  (data_out)
  );

endmodule

// File: doc/spram_v2.md
# spram_v2

Parametrised single-port synchronous RAM with a valid/ready request interface, per-byte write enables, and a selectable 1- or 2-cycle read latency. After every reset a clear sequencer zeroes the whole array, one word per cycle. Out-of-range addresses are reported instead of aliasing. It is the drop-in storage primitive for the SPRAM UVM environment and for any subsystem that needs a small on-chip scratch memory.

## Interface
- `D_WIDTH`, 32, data width; must be a multiple of 8.
- `A_WIDTH`, 4, address width.
- `MEM_DEPTH`, 16, number of words; 1 ≤ `MEM_DEPTH` ≤ 2^`A_WIDTH`.
- `RD_LATENCY`, 1, read latency in cycles; legal values are 1 or 2.
- `clk`  in  1  single clock; everything is on the rising edge.
- `rst_n`  in  1  reset: synchronous and active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request.
- `wr_en`  in  1  1 = write, 0 = read; sampled on acceptance.
- `address`  in  `A_WIDTH`  word address.
- `data_in`  in  `D_WIDTH`  write data.
- `byte_en`  in  `D_WIDTH/8`  per-byte write enable; ignored on reads.
- `data_out`  out  `D_WIDTH`  read data.
- `valid_out`  out  1  one-cycle pulse marking a read response.
- `err`  out  1  error flag, qualified by `valid_out`.

## Operation
- **Acceptance:** a request is accepted on a rising edge where `req_valid && req_ready`. `req_valid` without `req_ready` is ignored; nothing is queued.
- **FSM states:** CLEAR and READY.
  - Reset forces CLEAR with the clear counter at 0.
  - In CLEAR, each edge with `rst_n`=1 writes 0 to `mem[cnt]` and increments `cnt`.
  - The edge that writes `MEM_DEPTH-1` moves the FSM to READY.
  - In CLEAR, `req_ready`=0. In READY, `req_ready`=1, held constant. READY has no exit except reset.
- **Write:** for each byte `b` with `byte_en[b]`=1, `mem[address]` byte `b` takes `data_in` byte `b`. Other bytes are unchanged.
  - A write produces no response: `valid_out` stays 0 and `data_out` is not updated.
  - `byte_en`=0 is a legal no-op write.
- **Read:** the response is `data_out` = `mem[address]` with `valid_out`=1 and `err`=0.
- **Address out of range** (`address` ≥ `MEM_DEPTH`):
  - A write is dropped with no side effects.
  - A read returns `data_out`=0 and `err`=1.
- **Concurrency:** one request per cycle, with back-to-back reads at full rate. A read in the cycle after a write to the same address returns the new data.
- **Between pulses:** `data_out` holds the last response value. `err` is 0 whenever `valid_out`=0.
- **Reset during operation:** in-flight read responses are discarded, with no `valid_out` pulse. The array is re-cleared from word 0.

## Timing
- **Reset values:** `req_ready`=0, `valid_out`=0, `err`=0, `data_out`=0, pipeline flushed.
- **Clear duration:** `req_ready` rises after exactly `MEM_DEPTH` edges with `rst_n`=1.
- **Read latency:** for a read accepted at edge N, `valid_out`/`data_out`/`err` are visible after edge N+`RD_LATENCY`.
  - `RD_LATENCY`=2 adds one output register after the array read.
  - Pulses are exactly 1 cycle per read, in order, with no bubbles inserted.
- **Write timing:** a write accepted at edge N updates the array at edge N.

## Configuration
- **Macro:** `SPRAM_PARITY_EN`.
- **When defined:**
  - Each byte is stored with one even-parity bit, computed from the written data.
  - On read, parity is recomputed. Any mismatch sets `err`=1 with the (unmodified) data.
  - The clear sequencer writes consistent parity, which is 0.
- **When undefined:**
  - No parity storage exists.
  - `err` reflects only the out-of-range condition.
- The port list is identical either way.

## Structure
- **Package `spram_pkg`:**
  - FSM state enum `spram_state_e` {CLEAR, READY}.
  - Localparams for the legal `RD_LATENCY` range.
  - Parity function `byte_parity`.
- **Sub-module `spram_rd_pipe`:** the `RD_LATENCY`-deep delay line carrying {valid, err, data}. It is flushed by `rst_n`.
- **Parameter checks:** an elaboration-time assertion rejects illegal `D_WIDTH`, `MEM_DEPTH` and `RD_LATENCY`.

## Test plan
- **Reset/clear:** defaults, assert `rst_n`=0 for 3 cycles then release → `req_ready`=0 for 16 edges, then 1. Reading addresses 0..15 then returns 0 with `err`=0.
- **Byte-enable write:** write 0xAABBCCDD to address 5 with `byte_en`=4'hF, then write 0x11223344 to address 5 with `byte_en`=4'b0101, then read address 5 → `data_out`=0xAA22CC44.
- **Latency:** with `RD_LATENCY`=2, read addresses 1, 2, 3 back-to-back → three consecutive `valid_out` pulses, the first 2 cycles after acceptance, in order.
- **Out of range:** with `MEM_DEPTH`=12, write 0xFFFF_FFFF to address 13, then read address 13 → `data_out`=0, `err`=1. Reading address 0 afterwards returns the prior value.
- **Reset during clear/reads:** issue reads, then assert `rst_n`=0 on the cycle after acceptance → no `valid_out` pulse. After release, the full clear is repeated and previously written data reads as 0.
- **Parity (macro on):** write 0x000000FF, flip a stored bit by force, then read → `err`=1 with the corrupted data. A clean read of another address → `err`=0.
